// File: rtl/captura_display.sv
// Display loopback monitor: watches a multiplexed 4-digit 7-segment scan and
// rebuilds the BCD digits and binary value of each complete uni..milla frame.
module captura_display #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uni,
    input  logic        dece,
    input  logic        cente,
    input  logic        milla,
    input  logic [6:0]  seg,
    output logic [3:0]  dig_uni,
    output logic [3:0]  dig_dece,
    output logic [3:0]  dig_cente,
    output logic [3:0]  dig_milla,
    output logic [13:0] valor,
    output logic        frame_valid,
    output logic        err_anodo,
    output logic        err_seg,
    output logic        err_orden
);

    typedef enum logic [1:0] {ESPERA, ESP_D, ESP_C, ESP_M} estado_t;
    typedef enum logic [2:0] {P_NONE, P_UNI, P_DECE, P_CENTE, P_MILLA} pos_t;

    localparam logic [7:0] SETTLE_C = 8'(SETTLE);

    estado_t     estado;
    pos_t        ultima;
    logic [10:0] prev_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic [3:0]  sh_uni, sh_dece, sh_cente;

    logic [3:0]  en, activos;
    logic        blank, same, sample, multi, dec_ok;
    logic [3:0]  bcd;
    pos_t        pos, esperada;

    assign en      = {milla, cente, dece, uni};
    assign activos = ~en;
    assign blank   = &en;
    assign same    = ({en, seg} == prev_q);
    assign multi   = (activos & (activos - 4'd1)) != 4'd0;

    always_comb begin
        if (blank) begin
            cnt_d = 8'd0;
        end else if (same) begin
            cnt_d = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
        end else begin
            cnt_d = 8'd1;
        end
    end

    // A saturated counter sitting at SETTLE must not resample the same window.
    assign sample = !blank && (cnt_d == SETTLE_C) && !(same && (cnt_q == SETTLE_C));

    always_comb begin
        dec_ok = 1'b1;
        bcd    = 4'd0;
        case (seg)
            7'h40: bcd = 4'd0;
            7'h79: bcd = 4'd1;
            7'h24: bcd = 4'd2;
            7'h30: bcd = 4'd3;
            7'h19: bcd = 4'd4;
            7'h12: bcd = 4'd5;
            7'h02: bcd = 4'd6;
            7'h78: bcd = 4'd7;
            7'h00: bcd = 4'd8;
            7'h10: bcd = 4'd9;
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        case (activos)
            4'b0001: pos = P_UNI;
            4'b0010: pos = P_DECE;
            4'b0100: pos = P_CENTE;
            4'b1000: pos = P_MILLA;
            default: pos = P_NONE;
        endcase
    end

    always_comb begin
        case (estado)
            ESP_D:   esperada = P_DECE;
            ESP_C:   esperada = P_CENTE;
            ESP_M:   esperada = P_MILLA;
            default: esperada = P_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado      <= ESPERA;
            ultima      <= P_NONE;
            prev_q      <= '1;
            cnt_q       <= 8'd0;
            sh_uni      <= 4'd0;
            sh_dece     <= 4'd0;
            sh_cente    <= 4'd0;
            dig_uni     <= 4'd0;
            dig_dece    <= 4'd0;
            dig_cente   <= 4'd0;
            dig_milla   <= 4'd0;
            valor       <= 14'd0;
            frame_valid <= 1'b0;
            err_anodo   <= 1'b0;
            err_seg     <= 1'b0;
            err_orden   <= 1'b0;
        end else begin
            prev_q      <= {en, seg};
            cnt_q       <= cnt_d;
            frame_valid <= 1'b0;
            err_anodo   <= 1'b0;
            err_seg     <= 1'b0;
            err_orden   <= 1'b0;
            if (sample) begin
                if (multi) begin
                    err_anodo <= 1'b1;
                    estado    <= ESPERA;
                    ultima    <= P_NONE;
                end else if (!dec_ok) begin
                    err_seg <= 1'b1;
                    estado  <= ESPERA;
                    ultima  <= P_NONE;
                end else if (pos == P_UNI) begin
                    sh_uni <= bcd;
                    estado <= ESP_D;
                    ultima <= P_UNI;
                end else if (pos == ultima) begin
                    if (pos == P_DECE) sh_dece <= bcd;
                    if (pos == P_CENTE) sh_cente <= bcd;
                end else if (pos == esperada) begin
                    ultima <= pos;
                    case (pos)
                        P_DECE: begin
                            sh_dece <= bcd;
                            estado  <= ESP_C;
                        end
                        P_CENTE: begin
                            sh_cente <= bcd;
                            estado   <= ESP_M;
                        end
                        default: begin
                            dig_uni     <= sh_uni;
                            dig_dece    <= sh_dece;
                            dig_cente   <= sh_cente;
                            dig_milla   <= bcd;
                            valor       <= 14'(bcd) * 14'd1000 + 14'(sh_cente) * 14'd100
                                         + 14'(sh_dece) * 14'd10 + 14'(sh_uni);
                            frame_valid <= 1'b1;
                            estado      <= ESPERA;
                            ultima      <= P_NONE;
                        end
                    endcase
                end else begin
                    err_orden <= 1'b1;
                    estado    <= ESPERA;
                    ultima    <= P_NONE;
                end
            end
        end
    end

endmodule

// File: doc/captura_display.md
Name: captura_display

Overview:
- Receive-side counterpart of the 4-digit multiplexed 7-segment scan interface.
- Watches the active-low digit enables (uni, dece, cente, milla) and the shared active-low segment bus.
- Decodes each digit window back to BCD, reassembles complete frames in scan order, and outputs four BCD digits plus the 14-bit binary value.
- Used as a display loopback monitor and for self-check of the display driver path.

Parameters:
SETTLE, 1, consecutive identical cycles of (enables, seg) required before a window is sampled; legal range 1..255.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
uni  input  1  units digit enable, active-low
dece  input  1  tens digit enable, active-low
cente  input  1  hundreds digit enable, active-low
milla  input  1  thousands digit enable, active-low
seg  input  7  segment bus, active-low, {g,f,e,d,c,b,a}
dig_uni  output  4  captured units BCD
dig_dece  output  4  captured tens BCD
dig_cente  output  4  captured hundreds BCD
dig_milla  output  4  captured thousands BCD
valor  output  14  milla*1000 + cente*100 + dece*10 + uni
frame_valid  output  1  one-cycle pulse, outputs updated
err_anodo  output  1  one-cycle pulse, more than one enable active
err_seg  output  1  one-cycle pulse, undecodable segment pattern
err_orden  output  1  one-cycle pulse, digit out of scan order

Behaviour:
- Reset (sync, active-high; wins over every other event): all dig_* = 0, valor = 0, frame_valid / err_* = 0, FSM = ESPERA, stability counter = 0, shadow digits = 0, last position = none.
- Reset asserted mid-frame discards the partial frame; outputs return to 0 at the next edge.
- Inputs share the clk domain. No synchronizers.
- Stability counter (8-bit, saturating):
  - If (enables, seg) equals the previous cycle, increment; otherwise load 1.
  - Loads 0 when all enables are high (blank). Blank never samples and never errors.
- Sample event: occurs in the cycle where the counter reaches SETTLE. At most one sample per window (window = maximal run of identical inputs).
- Segment decode (active-low hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Any other value is illegal.
- Sample evaluation, in priority order:
  1. More than one enable low: err_anodo, FSM to ESPERA.
  2. Illegal seg: err_seg, FSM to ESPERA, digit discarded.
  3. Position uni: store shadow uni, FSM to ESP_D (resync from any state, no error).
  4. Same position as the last accepted sample: overwrite that shadow digit, state unchanged.
  5. Position equals the expected one: store, advance.
  6. Otherwise: err_orden, FSM to ESPERA.
- FSM states and transitions:
  - ESPERA: only uni accepted.
  - ESP_D: dece expected, then to ESP_C.
  - ESP_C: cente expected, then to ESP_M.
  - ESP_M: milla expected; on accept, go to ESPERA and commit the frame.
- Frame commit:
  - At the edge ending the milla sample cycle, dig_* load from shadow digits plus the decoded milla.
  - valor loads the binary value of those same digits (range 0..9999, no overflow).
  - frame_valid = 1 for exactly that next cycle.
  - Latency: outputs and pulses visible 1 cycle after the sample cycle.
- Output holding: dig_* and valor hold their values between commits. Errors never modify them.
- Timing of err_* pulses: all err_* pulse 1 cycle after the offending sample cycle.
- Simultaneous events: err_* and frame_valid are never asserted in the same cycle.
- Compatibility: with SETTLE=1, a driver advancing one digit per clock (uni→dece→cente→milla, each held one cycle) produces one frame per 4 cycles.

Test Plan:
1. SETTLE=1, reset, then one cycle each: uni seg=19, dece seg=30, cente seg=24, milla seg=79 -> one cycle after milla: frame_valid=1, dig_milla=1, dig_cente=2, dig_dece=3, dig_uni=4, valor=1234; no err_*.
2. Frame of 9999 (all seg=10), then frame of 0000 (all seg=40) -> valor=9999, then valor=0; exactly two frame_valid pulses, 4 cycles apart.
3. SETTLE=3, windows held 2 cycles -> no frame_valid; same frame with windows held 3 cycles -> frame_valid, valor matches digits; blank cycles (enables=1111) inserted between windows -> no effect.
4. uni and dece low together at dece time -> err_anodo pulse; frame discarded, dig_* keep the previous frame; next clean frame 5678 -> valor=5678.
5. seg=7E during cente window -> err_seg, no frame_valid; sequence uni, cente -> err_orden; repeated dece with a new seg value -> overwrite, no error.
6. reset asserted for 1 cycle after dece sample of a frame, then full frame 4321 -> outputs 0 during reset, then valor=4321 with a single frame_valid.
